// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared constants and FSM state encoding for the iterative
//               shift engine and its barrel-shift stage.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int WIDTH    = 8;
    localparam int CNT_W    = 5;
    localparam int MAX_STEP = 7;
    localparam int STEP_W   = $clog2(MAX_STEP + 1);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/iterative_shifter_barrel.sv
`default_nettype none
// ============================================================================
// Module      : BarrelShifter
// Description : Combinational 8-bit logical barrel shifter, 3-bit shift
//               amount, zero fill, direction select (0 = left, 1 = right).
// Revision    : 1.0 - initial release
// ============================================================================
module BarrelShifter
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0]  in,
    input  logic [STEP_W-1:0] shamt,
    input  logic              dir,
    output logic [WIDTH-1:0]  out
);

    logic [WIDTH-1:0] w_stage;

    // Log-depth stages: stage s moves the word by 2**s when shamt[s] is set.
    always_comb begin
        w_stage = in;
        for (int s = 0; s < STEP_W; s++) begin
            if (shamt[s]) begin
                if (dir == DIR_RIGHT) begin
                    w_stage = w_stage >> (1 << s);
                end else begin
                    w_stage = w_stage << (1 << s);
                end
            end
        end
    end

    assign out = w_stage;

endmodule
`default_nettype wire

// File: rtl/iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iterative_shifter
// Description : Multi-cycle logical shifter; loops an accumulator through the
//               barrel stage in chunks of up to MAX_STEP positions per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_shifter #(
    parameter int WIDTH    = shifter_pkg::WIDTH,
    parameter int CNT_W    = shifter_pkg::CNT_W,
    parameter int MAX_STEP = shifter_pkg::MAX_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] count,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    import shifter_pkg::*;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_rem;
    logic               r_dir_q;
    logic [WIDTH-1:0]   r_dout;

    logic [STEP_W-1:0]  w_step;
    logic [CNT_W-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_shifted;

    // A zero count still takes one pass with step 0, so latency never drops
    // below one SHIFT cycle and the result path is always the barrel output.
    assign w_step     = (r_rem > CNT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP)
                                                   : r_rem[STEP_W-1:0];
    assign w_rem_next = r_rem - CNT_W'(w_step);

    BarrelShifter u_barrel (
        .in    (r_acc),
        .shamt (w_step),
        .dir   (r_dir_q),
        .out   (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_dir_q <= DIR_LEFT;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= din;
                        r_rem   <= count;
                        r_dir_q <= dir;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_shifted;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_dout  <= w_shifted;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);
    assign dout = r_dout;

endmodule
`default_nettype wire
